// File: rtl/alu_pkg.sv
// Opcode constants and enum shared by rv32_alu_core and the enclosing ALU decoder.
package alu_pkg;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ADD     = 5'd1;
    localparam logic [4:0] SUB     = 5'd2;
    localparam logic [4:0] SLL     = 5'd3;
    localparam logic [4:0] XOR     = 5'd4;
    localparam logic [4:0] SRL     = 5'd5;
    localparam logic [4:0] OR      = 5'd6;
    localparam logic [4:0] AND     = 5'd7;

    typedef enum logic [4:0] {
        OP_NOP = ALU_NOP,
        OP_ADD = ADD,
        OP_SUB = SUB,
        OP_SLL = SLL,
        OP_XOR = XOR,
        OP_SRL = SRL,
        OP_OR  = OR,
        OP_AND = AND
    } alu_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit logical barrel shifter, five log stages, left or right.
module alu_shifter (
    input  logic [31:0] data,
    input  logic [4:0]  amount,
    input  logic        right,
    output logic [31:0] result
);

    logic [5:0][31:0] stage;

    assign stage[0] = data;

    // Stage i shifts by 2^i when amount[i] is set; both directions zero-fill.
    for (genvar i = 0; i < 5; i++) begin : g_stage
        assign stage[i+1] = !amount[i] ? stage[i] :
                            right      ? (stage[i] >> (1 << i)) :
                                         (stage[i] << (1 << i));
    end

    assign result = stage[5];

endmodule

// File: rtl/rv32_alu_core.sv
// Registered RV32I reg-reg datapath: ADD/SUB/SLL/XOR/SRL/OR/AND, zero for other codes.
module rv32_alu_core
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  alu_control,
    output logic [31:0] rd_write_val
);

    alu_op_t     op;
    logic [31:0] shift_res;
    logic [31:0] result;

    assign op = alu_op_t'(alu_control);

    alu_shifter u_shifter (
        .data   (rs1_val),
        .amount (rs2_val[4:0]),
        .right  (op == OP_SRL),
        .result (shift_res)
    );

    always_comb begin
        result = 32'h0;
        case (op)
            OP_ADD:  result = rs1_val + rs2_val;
            OP_SUB:  result = rs1_val - rs2_val;
            OP_SLL:  result = shift_res;
            OP_SRL:  result = shift_res;
            OP_XOR:  result = rs1_val ^ rs2_val;
            OP_OR:   result = rs1_val | rs2_val;
            OP_AND:  result = rs1_val & rs2_val;
            default: result = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_write_val <= 32'h0;
        else        rd_write_val <= result;
    end

endmodule

// File: tb/tb_rv32_alu_core.sv
// Directed and random checks of rv32_alu_core against a one-cycle-delayed reference.
module tb_rv32_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  alu_control;
    logic [31:0] rd_write_val;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q;

    rv32_alu_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .alu_control  (alu_control),
        .rd_write_val (rd_write_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = b % 32;
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a << sh;
            5'd4:    return a ^ b;
            5'd5:    return a >> sh;
            5'd6:    return a | b;
            5'd7:    return a & b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one op just after an edge, confirm the output holds until the
    // next edge, then check the registered result just after it.
    task automatic step(input logic r, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
        rst_n = r; alu_control = op; rs1_val = a; rs2_val = b;
        #2;
        check({tag, "_hold"}, rd_write_val, exp_q);
        @(posedge clk); #1;
        exp_q = r ? ref_alu(op, a, b) : 32'h0;
        check(tag, rd_write_val, exp_q);
    endtask

    initial begin
        logic        r;
        logic [4:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0; alu_control = 5'd1; rs1_val = 32'd5; rs2_val = 32'd7;
        @(posedge clk); #1;
        exp_q = 32'h0;
        check("reset0", rd_write_val, 32'h0);
        step(1'b0, 5'd1, 32'd5, 32'd7, "reset1");
        step(1'b1, 5'd1, 32'd5, 32'd7, "rel_add");
        check("rel_add_12", rd_write_val, 32'd12);

        step(1'b1, 5'd1, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        check("add_wrap_c", rd_write_val, 32'h0);
        step(1'b1, 5'd2, 32'd0, 32'd1, "sub_wrap");
        check("sub_wrap_c", rd_write_val, 32'hFFFF_FFFF);
        step(1'b1, 5'd2, 32'd10, 32'd3, "sub_7");
        check("sub_7_c", rd_write_val, 32'd7);

        step(1'b1, 5'd3, 32'd1, 32'd31, "sll31");
        check("sll31_c", rd_write_val, 32'h8000_0000);
        step(1'b1, 5'd3, 32'd1, 32'h21, "sll_mask");
        check("sll_mask_c", rd_write_val, 32'd2);
        step(1'b1, 5'd5, 32'h8000_0000, 32'd31, "srl31");
        check("srl31_c", rd_write_val, 32'd1);
        step(1'b1, 5'd5, 32'hF000_0000, 32'd4, "srl_zf");
        check("srl_zf_c", rd_write_val, 32'h0F00_0000);
        step(1'b1, 5'd3, 32'hDEAD_BEEF, 32'hFFFF_FFE0, "sll0");
        check("sll0_c", rd_write_val, 32'hDEAD_BEEF);
        step(1'b1, 5'd5, 32'h1234_5678, 32'd0, "srl0");
        check("srl0_c", rd_write_val, 32'h1234_5678);

        step(1'b1, 5'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, "xor");
        check("xor_c", rd_write_val, 32'hFF00_EDCB);
        step(1'b1, 5'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, "or");
        check("or_c", rd_write_val, 32'hFFF0_FFFF);
        step(1'b1, 5'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
        check("and_c", rd_write_val, 32'h00F0_1234);

        step(1'b1, 5'd0,  32'h1111_1111, 32'h2222_2222, "nop0");
        check("nop0_c", rd_write_val, 32'h0);
        step(1'b1, 5'd8,  32'h1111_1111, 32'h2222_2222, "nop8");
        check("nop8_c", rd_write_val, 32'h0);
        step(1'b1, 5'd13, 32'h1111_1111, 32'h2222_2222, "nop13");
        check("nop13_c", rd_write_val, 32'h0);
        step(1'b1, 5'd31, 32'h1111_1111, 32'h2222_2222, "nop31");
        check("nop31_c", rd_write_val, 32'h0);

        // Mid-stream reset with an op that would otherwise be nonzero.
        step(1'b0, 5'd6, 32'hFFFF_0000, 32'h0000_FFFF, "mid_rst");
        check("mid_rst_c", rd_write_val, 32'h0);

        for (int i = 0; i < 10000; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            step(r, op, a, b, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
